snitch_tcdm_router_pipe: RTL and testbench
==========================================

Name: snitch_tcdm_router_pipe

Overview:
Next-generation TCDM interconnect between NumInp requestors (cores, DMA, accelerators) and NumOut word-interleaved SRAM banks in the Snitch cluster.
- Routes requests through a round-robin crossbar with lock-in.
- Supports banks with any fixed response latency (RespLatency ≥ 1).
- Optionally registers the response path for timing.
- Provides per-input saturating bank-conflict counters for performance analysis.

Parameters:
- AddrWidth, 32, master-side address width.
- DataWidth, 32, data width; ByteOffset = log2(DataWidth/8).
- NumInp, 5, number of master ports (>0).
- NumOut, 8, number of bank ports; power of two, ≥1.
- MemCoallWidth, 0, address bits above ByteOffset kept inside a bank (coalescing granularity).
- RespLatency, 1, fixed bank latency in cycles from q handshake to p.data valid (≥1).
- RegisterRsp, 0, 1 = add one register stage on mst p path.
- CntWidth, 16, width of each conflict counter.
- tcdm_req_t, logic, request struct type (q_valid, q{addr,write,amo,data,strb,user}).
- tcdm_rsp_t, logic, response struct type (q_ready, p_valid, p{data}).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mst_req_i  in  NumInp x tcdm_req_t  master requests.
- mst_rsp_o  out  NumInp x tcdm_rsp_t  master responses.
- agnt_req_o  out  NumOut x tcdm_req_t  bank requests.
- agnt_rsp_i  in  NumOut x tcdm_rsp_t  bank responses.
- clear_cnt_i  in  1  synchronous clear of all conflict counters.
- conflict_cnt_o  out  NumInp x CntWidth  per-input conflict cycle count.

Behaviour:
Bank select and address
- SelWidth = log2(NumOut); sel = addr[ByteOffset+MemCoallWidth +: SelWidth].
- Forwarded addr = {addr[AddrWidth-1 : ByteOffset+MemCoallWidth+SelWidth], addr[ByteOffset+MemCoallWidth-1:0]}, zero-extended into the struct field.
- NumOut=1: sel constant 0, address passed unchanged.

Request side (combinational, zero added latency)
- Per-output round-robin arbiter over inputs with q_valid and matching sel.
- agnt q_valid = any requester; agnt q = winner payload (write, amo, data, strb, user unmodified).
- mst q_ready[i] = granted[i] & agnt q_ready[sel[i]].
- Lock-in: if an output has q_valid=1 and q_ready=0, the same winner is held next cycle, so the output payload is stable until handshake.
- RR pointer advances to winner+1 (mod NumInp) only on handshake.
- Requests from one input are never reordered.

Response side
- Per input, a RespLatency-deep shift register of {valid, sel}, loaded every cycle with {q_valid&q_ready, sel}.
- At tap RespLatency: p_valid = valid; p.data = agnt_rsp_i[sel].p.data.
- Total latency: RespLatency (RegisterRsp=0) or RespLatency+1 (RegisterRsp=1).
- Back-to-back handshakes yield back-to-back responses; no p_ready exists and responses are never dropped except by reset.
- mst p.data is don't-care when p_valid=0. Registers load data only when the tap is valid.

Conflict counters
- Increment per cycle when q_valid[i] & !q_ready[i].
- Saturate at 2^CntWidth-1.
- clear_cnt_i has priority over increment; clearing writes 0.

Reset
- p_valid = 0 for all inputs; shift registers, RR pointers and lock state cleared; counters = 0.
- q_ready/q_valid are combinational and reflect inputs immediately.
- Reset mid-operation discards in-flight responses: no p_valid is produced for pre-reset handshakes, even if banks return data.

Test Plan:
- NumInp=2, NumOut=4, RespLatency=1. In0 reads 0x0000_0008 → agnt[2] q_valid, forwarded addr 0x0; mst[0] p_valid exactly 1 cycle after handshake with bank 2 data.
- Both inputs request bank 1 for 4 cycles, agnt always ready → grants alternate 0,1,0,1; each input's conflict_cnt_o = 2.
- Bank 3 holds q_ready=0 for 3 cycles while in1 waits → agnt[3] payload stable all 3 cycles; in0 arriving at bank 3 cycle 2 is not granted until in1 handshakes.
- RespLatency=3, RegisterRsp=1; in0 issues 4 back-to-back reads to banks 0,1,2,3 → 4 consecutive p_valid starting 4 cycles after first handshake, data in issue order.
- CntWidth=2; in0 blocked 6 cycles → counter saturates at 3; clear_cnt_i asserted in a blocked cycle → 0 next cycle.
- Handshake at cycle t, RespLatency=2, rst_ni low at t+1 → no p_valid at t+2; all counters 0 and RR pointer at 0 after release.

Source files
------------

// File: rtl/snitch_tcdm_router_pipe.sv
// snitch_tcdm_router_pipe: round-robin TCDM crossbar, NumInp masters to NumOut banks.
// Ports: clk_i/rst_ni, mst_req_i/mst_rsp_o, agnt_req_o/agnt_rsp_i, clear_cnt_i, conflict_cnt_o.

package tcdm_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic [31:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;
endpackage

module snitch_tcdm_router_pipe #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumInp        = 5,
  parameter int unsigned NumOut        = 8,
  parameter int unsigned MemCoallWidth = 0,
  parameter int unsigned RespLatency   = 1,
  parameter bit          RegisterRsp   = 1'b0,
  parameter int unsigned CntWidth      = 16,
  parameter type tcdm_req_t = tcdm_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = tcdm_pkg::tcdm_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tcdm_req_t           mst_req_i [NumInp],
  output tcdm_rsp_t           mst_rsp_o [NumInp],
  output tcdm_req_t           agnt_req_o [NumOut],
  input  tcdm_rsp_t           agnt_rsp_i [NumOut],
  input  logic                clear_cnt_i,
  output logic [CntWidth-1:0] conflict_cnt_o [NumInp]
);

  localparam int unsigned ByteOffset = $clog2(DataWidth / 8);
  localparam int unsigned SelBits    = $clog2(NumOut);
  localparam int unsigned SelWidth   = (SelBits > 0) ? SelBits : 1;
  localparam int unsigned LowBits    = ByteOffset + MemCoallWidth;
  localparam int unsigned IdxWidth   = (NumInp > 1) ? $clog2(NumInp) : 1;

  localparam logic [AddrWidth-1:0] LowMask =
    AddrWidth'((64'd1 << LowBits) - 64'd1);
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef logic [SelWidth-1:0] sel_t;
  typedef logic [IdxWidth-1:0] idx_t;

  logic [AddrWidth-1:0] addr     [NumInp];
  logic [AddrWidth-1:0] fwd_addr [NumInp];
  sel_t                 sel      [NumInp];

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      addr[i] = mst_req_i[i].q.addr;
      // The bank-select field is squeezed out of the forwarded address.
      fwd_addr[i] = ((addr[i] >> (LowBits + SelBits)) << LowBits)
                  | (addr[i] & LowMask);
      if (SelBits == 0) sel[i] = '0;
      else              sel[i] = addr[i][LowBits +: SelWidth];
    end
  end

  logic [NumInp-1:0] req       [NumOut];
  logic              out_valid [NumOut];
  idx_t              winner    [NumOut];
  idx_t              rr_ptr_q  [NumOut];
  logic              lock_q    [NumOut];
  idx_t              lock_idx_q[NumOut];

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    for (int j = 0; j < NumOut; j++) begin
      req[j] = '0;
      for (int i = 0; i < NumInp; i++) begin
        req[j][i] = mst_req_i[i].q_valid && (sel[i] == sel_t'(j));
      end
      out_valid[j] = |req[j];
      winner[j]    = '0;
      found        = 1'b0;
      // A stalled output keeps its previous winner so its payload holds.
      if (lock_q[j] && req[j][lock_idx_q[j]]) begin
        winner[j] = lock_idx_q[j];
      end else begin
        for (int k = 0; k < NumInp; k++) begin
          c = int'(rr_ptr_q[j]) + k;
          if (c >= NumInp) c = c - NumInp;
          if (!found && req[j][c]) begin
            winner[j] = idx_t'(c);
            found     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NumOut; j++) begin
      agnt_req_o[j]         = '0;
      agnt_req_o[j].q       = mst_req_i[winner[j]].q;
      agnt_req_o[j].q.addr  = fwd_addr[winner[j]];
      agnt_req_o[j].q_valid = out_valid[j];
    end
  end

  logic [NumInp-1:0] q_ready;
  logic [NumInp-1:0] hs;

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      q_ready[i] = mst_req_i[i].q_valid
                && out_valid[sel[i]]
                && (winner[sel[i]] == idx_t'(i))
                && agnt_rsp_i[sel[i]].q_ready;
      hs[i] = mst_req_i[i].q_valid && q_ready[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NumOut; j++) begin
        rr_ptr_q[j]   <= '0;
        lock_q[j]     <= 1'b0;
        lock_idx_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NumOut; j++) begin
        lock_q[j] <= out_valid[j] && !agnt_rsp_i[j].q_ready;
        if (out_valid[j] && !agnt_rsp_i[j].q_ready) begin
          lock_idx_q[j] <= winner[j];
        end
        if (out_valid[j] && agnt_rsp_i[j].q_ready) begin
          if (winner[j] == idx_t'(NumInp - 1)) rr_ptr_q[j] <= '0;
          else rr_ptr_q[j] <= winner[j] + idx_t'(1);
        end
      end
    end
  end

  logic vld_q [NumInp][RespLatency];
  sel_t sel_q [NumInp][RespLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInp; i++) begin
        for (int k = 0; k < RespLatency; k++) begin
          vld_q[i][k] <= 1'b0;
          sel_q[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        vld_q[i][0] <= hs[i];
        sel_q[i][0] <= sel[i];
        for (int k = 1; k < RespLatency; k++) begin
          vld_q[i][k] <= vld_q[i][k-1];
          sel_q[i][k] <= sel_q[i][k-1];
        end
      end
    end
  end

  logic                 tap_valid [NumInp];
  logic [DataWidth-1:0] tap_data  [NumInp];
  logic                 rsp_valid [NumInp];
  logic [DataWidth-1:0] rsp_data  [NumInp];

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      tap_valid[i] = vld_q[i][RespLatency-1];
      tap_data[i]  = agnt_rsp_i[sel_q[i][RespLatency-1]].p.data;
    end
  end

  if (RegisterRsp) begin : g_reg
    logic                 pv_q [NumInp];
    logic [DataWidth-1:0] pd_q [NumInp];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < NumInp; i++) begin
          pv_q[i] <= 1'b0;
          pd_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NumInp; i++) begin
          pv_q[i] <= tap_valid[i];
          if (tap_valid[i]) pd_q[i] <= tap_data[i];
        end
      end
    end

    always_comb begin
      for (int i = 0; i < NumInp; i++) begin
        rsp_valid[i] = pv_q[i];
        rsp_data[i]  = pd_q[i];
      end
    end
  end else begin : g_comb
    always_comb begin
      for (int i = 0; i < NumInp; i++) begin
        rsp_valid[i] = tap_valid[i];
        rsp_data[i]  = tap_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      mst_rsp_o[i]         = '0;
      mst_rsp_o[i].q_ready = q_ready[i];
      mst_rsp_o[i].p_valid = rsp_valid[i];
      mst_rsp_o[i].p.data  = rsp_data[i];
    end
  end

  logic [CntWidth-1:0] cnt_q [NumInp];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInp; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (clear_cnt_i) begin
          cnt_q[i] <= '0;
        end else if (mst_req_i[i].q_valid && !q_ready[i]
                     && (cnt_q[i] != CntMax)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumInp; i++) conflict_cnt_o[i] = cnt_q[i];
  end

  // Banks signal data validity by fixed latency, not by p_valid.
  logic unused_p_valid;
  always_comb begin
    unused_p_valid = 1'b0;
    for (int j = 0; j < NumOut; j++) begin
      unused_p_valid = unused_p_valid ^ agnt_rsp_i[j].p_valid;
    end
  end

endmodule

// File: tb/tb_snitch_tcdm_router_pipe.sv
// tb_snitch_tcdm_router_pipe: two router instances (latency 1 comb / latency 3 registered)
// driven with directed vectors; responses checked by a scoreboard monitor.

module tb_snitch_tcdm_router_pipe;
  import tcdm_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  exp_t sbq [4][$];

  tcdm_req_t   mreq_a [2];
  tcdm_rsp_t   mrsp_a [2];
  tcdm_req_t   areq_a [4];
  tcdm_rsp_t   arsp_a [4];
  logic        clr_a  = 1'b0;
  logic [1:0]  cnt_a  [2];

  tcdm_req_t   mreq_b [2];
  tcdm_rsp_t   mrsp_b [2];
  tcdm_req_t   areq_b [4];
  tcdm_rsp_t   arsp_b [4];
  logic        clr_b  = 1'b0;
  logic [15:0] cnt_b  [2];

  logic        stall_a [4];
  logic        stall_b [4];
  logic [31:0] bank_a  [4];
  logic [31:0] bank_b  [4][3];

  logic [31:0] t2a0 [4] = '{32'h004, 32'h104, 32'h104, 32'h204};
  logic [31:0] t2a1 [4] = '{32'h014, 32'h014, 32'h114, 32'h114};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snitch_tcdm_router_pipe #(
    .AddrWidth(32), .DataWidth(32), .NumInp(2), .NumOut(4),
    .MemCoallWidth(0), .RespLatency(1), .RegisterRsp(1'b0),
    .CntWidth(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_req_i(mreq_a), .mst_rsp_o(mrsp_a),
    .agnt_req_o(areq_a), .agnt_rsp_i(arsp_a),
    .clear_cnt_i(clr_a), .conflict_cnt_o(cnt_a)
  );

  snitch_tcdm_router_pipe #(
    .AddrWidth(32), .DataWidth(32), .NumInp(2), .NumOut(4),
    .MemCoallWidth(0), .RespLatency(3), .RegisterRsp(1'b1),
    .CntWidth(16)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_req_i(mreq_b), .mst_rsp_o(mrsp_b),
    .agnt_req_o(areq_b), .agnt_rsp_i(arsp_b),
    .clear_cnt_i(clr_b), .conflict_cnt_o(cnt_b)
  );

  function automatic logic [31:0] bank_word(input int j, input logic [31:0] a);
    return 32'hB000_0000 | (32'(j) << 24) | {8'h00, a[23:0]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] f;
    f = {2'b00, a[31:4], a[1:0]};
    return bank_word(int'(a[3:2]), f);
  endfunction

  // Fixed-latency bank models.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      bank_a[j] <= (areq_a[j].q_valid && !stall_a[j])
                 ? bank_word(j, areq_a[j].q.addr) : 32'hDEAD_BEEF;
      bank_b[j][0] <= (areq_b[j].q_valid && !stall_b[j])
                    ? bank_word(j, areq_b[j].q.addr) : 32'hDEAD_BEEF;
      bank_b[j][1] <= bank_b[j][0];
      bank_b[j][2] <= bank_b[j][1];
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      arsp_a[j]         = '0;
      arsp_a[j].q_ready = !stall_a[j];
      arsp_a[j].p.data  = bank_a[j];
      arsp_b[j]         = '0;
      arsp_b[j].q_ready = !stall_b[j];
      arsp_b[j].p.data  = bank_b[j][2];
    end
  end

  logic unused_tb;
  always_comb begin
    unused_tb = 1'b0;
    for (int j = 0; j < 4; j++) unused_tb = unused_tb ^ (^areq_a[j]) ^ (^areq_b[j]);
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int q, input logic [31:0] d);
    exp_t e;
    n_chk++;
    if (sbq[q].size() == 0) begin
      n_fail++;
      $display("FAIL rsp_unexpected port%0d: got p_valid data %h at cycle %0d, required none",
               q, d, cyc);
    end else begin
      e = sbq[q].pop_front();
      if (d !== e.data || (e.due >= 0 && cyc != e.due)) begin
        n_fail++;
        $display("FAIL rsp port%0d: got %h at cycle %0d, required %h at cycle %0d",
                 q, d, cyc, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (mrsp_a[i].p_valid) mon(i, mrsp_a[i].p.data);
        if (mrsp_b[i].p_valid) mon(2 + i, mrsp_b[i].p.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic put(input bit b, input int i, input logic v,
                     input logic [31:0] a);
    tcdm_req_t r;
    r         = '0;
    r.q_valid = v;
    r.q.addr  = a;
    r.q.data  = ~a;
    r.q.strb  = 4'hF;
    r.q.user  = 2'(i + 1);
    if (b) mreq_b[i] = r;
    else   mreq_a[i] = r;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      put(1'b0, i, 1'b0, 32'h0);
      put(1'b1, i, 1'b0, 32'h0);
    end
  endtask

  task automatic push(input int q, input logic [31:0] a, input int due);
    exp_t e;
    e.data = exp_word(a);
    e.due  = due;
    sbq[q].push_back(e);
  endtask

  task automatic clear_a();
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      stall_a[j] = 1'b0;
      stall_b[j] = 1'b0;
    end
    idle();
    #1 rst_n = 1'b0;

    // Reset state
    settle();
    for (int i = 0; i < 2; i++) begin
      chk("rst_p_valid", {mrsp_a[i].p_valid, mrsp_b[i].p_valid}, 0);
      chk("rst_cnt", {cnt_a[i], cnt_b[i]}, 0);
    end
    tick();
    tick();
    rst_n = 1'b1;

    // Single read routed to bank 2, address field squeezed
    tick();
    put(1'b0, 0, 1'b1, 32'h8);
    push(0, 32'h8, cyc + 1);
    settle();
    chk("t1_agnt2_valid", areq_a[2].q_valid, 1);
    chk("t1_agnt0_valid", areq_a[0].q_valid, 0);
    chk("t1_fwd_addr", areq_a[2].q.addr, 0);
    chk("t1_payload", {areq_a[2].q.write, areq_a[2].q.data,
                       areq_a[2].q.strb, areq_a[2].q.user},
                      {1'b0, ~32'h8, 4'hF, 2'd1});
    chk("t1_q_ready", mrsp_a[0].q_ready, 1);
    tick();
    idle();

    // Round-robin on bank 1 with both inputs
    for (int k = 0; k < 4; k++) begin
      tick();
      put(1'b0, 0, 1'b1, t2a0[k]);
      put(1'b0, 1, 1'b1, t2a1[k]);
      if (k % 2 == 0) push(0, t2a0[k], cyc + 1);
      else            push(1, t2a1[k], cyc + 1);
      settle();
      chk("t2_rdy0", mrsp_a[0].q_ready, (k % 2 == 0));
      chk("t2_rdy1", mrsp_a[1].q_ready, (k % 2 == 1));
      chk("t2_winner_user", areq_a[1].q.user, (k % 2) + 1);
    end
    tick();
    idle();
    settle();
    chk("t2_cnt0", cnt_a[0], 2);
    chk("t2_cnt1", cnt_a[1], 2);
    clear_a();

    // Bank 3 stall: lock-in holds in1 even when in0 arrives
    for (int k = 0; k < 5; k++) begin
      tick();
      stall_a[3] = (k < 3);
      put(1'b0, 1, (k <= 3), 32'h0C);
      put(1'b0, 0, (k >= 2), 32'h1C);
      if (k == 3) push(1, 32'h0C, cyc + 1);
      if (k == 4) push(0, 32'h1C, cyc + 1);
      settle();
      chk("t3_rdy0", mrsp_a[0].q_ready, (k == 4));
      chk("t3_rdy1", mrsp_a[1].q_ready, (k == 3));
      if (k <= 3) chk("t3_hold", {areq_a[3].q.user, areq_a[3].q.addr}, {2'd2, 32'h0});
      else        chk("t3_next", {areq_a[3].q.user, areq_a[3].q.addr}, {2'd1, 32'h4});
    end
    tick();
    idle();
    settle();
    chk("t3_cnt0", cnt_a[0], 2);
    chk("t3_cnt1", cnt_a[1], 3);
    clear_a();

    // Saturation and clear priority on a 2-bit counter
    for (int k = 0; k < 8; k++) begin
      tick();
      put(1'b0, 0, 1'b1, 32'h0);
      stall_a[0] = (k < 7);
      clr_a      = (k == 6);
      if (k == 7) push(0, 32'h0, cyc + 1);
      settle();
      chk("t5_cnt", cnt_a[0], (k == 7) ? 0 : ((k < 3) ? k : 3));
      chk("t5_rdy", mrsp_a[0].q_ready, (k == 7));
    end
    tick();
    idle();
    clr_a = 1'b0;
    settle();
    chk("t5_cnt_after", cnt_a[0], 0);

    // Back-to-back reads on the latency-3 registered instance
    for (int k = 0; k < 4; k++) begin
      tick();
      put(1'b1, 0, 1'b1, 32'h40 + 32'(4 * k));
      push(2, 32'h40 + 32'(4 * k), cyc + 4);
      settle();
      chk("t4_rdy", mrsp_b[0].q_ready, 1);
    end
    tick();
    idle();
    for (int k = 0; k < 6; k++) tick();

    // Reset discards in-flight responses and clears RR/counters
    tick();
    put(1'b1, 0, 1'b1, 32'h100);
    put(1'b1, 1, 1'b1, 32'h200);
    settle();
    chk("t6_pre_rdy0", mrsp_b[0].q_ready, 0);
    chk("t6_pre_rdy1", mrsp_b[1].q_ready, 1);
    tick();
    put(1'b1, 1, 1'b0, 32'h0);
    settle();
    chk("t6_hs_rdy0", mrsp_b[0].q_ready, 1);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("t6_cnt0", cnt_b[0], 0);
    chk("t6_cnt1", cnt_b[1], 0);
    tick();
    put(1'b1, 0, 1'b1, 32'h100);
    put(1'b1, 1, 1'b1, 32'h200);
    push(2, 32'h100, cyc + 4);
    settle();
    chk("t6_rr_rdy0", mrsp_b[0].q_ready, 1);
    chk("t6_rr_rdy1", mrsp_b[1].q_ready, 0);
    tick();
    put(1'b1, 0, 1'b0, 32'h0);
    push(3, 32'h200, cyc + 4);
    settle();
    chk("t6_rr_rdy1b", mrsp_b[1].q_ready, 1);
    tick();
    idle();
    for (int k = 0; k < 8; k++) tick();

    settle();
    for (int q = 0; q < 4; q++) chk("sb_drain", sbq[q].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
